// File: rtl/arb_grant_mux_if.sv
// arb_grant_mux_if: grant/payload inputs and valid/ready FIFO output of the grant mux
interface arb_grant_mux_if #(
    parameter int REQ_NUM = 11,
    parameter int DW = 32
);
    localparam int IW = $clog2(REQ_NUM);
    logic [REQ_NUM-1:0] grant;
    logic [REQ_NUM*DW-1:0] req_data;
    logic arb_en;
    logic [REQ_NUM-1:0] req_ack;
    logic out_valid;
    logic out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;
    modport master (
        output grant, req_data, out_ready,
        input arb_en, req_ack, out_valid, out_data, out_id
    );
    modport slave (
        input grant, req_data, out_ready,
        output arb_en, req_ack, out_valid, out_data, out_id
    );
endinterface

// File: rtl/arb_grant_mux.sv
// arb_grant_mux: selects the granted payload and queues {id, payload} in a small FIFO
// Optional ARB_GRANT_MUX_ONEHOT_CHK_EN adds a sticky onehot_err flag for multi-hot grants.
module arb_grant_mux #(
    parameter int REQ_NUM = 11,
    parameter int DW = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst,
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
    output logic onehot_err,
`endif
    arb_grant_mux_if.slave bus
);
    localparam int IW = $clog2(REQ_NUM);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] data_mem [FIFO_DEPTH];
    logic [IW-1:0] id_mem [FIFO_DEPTH];
    logic [IW-1:0] idx;
    logic [DW-1:0] sel_data;
    logic push, pop;
    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        sel_data = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (bus.grant[i]) begin
                idx = IW'(i);
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end
    // Enable looks only at registered occupancy, so a pop at full cannot admit a push.
    assign bus.arb_en = ~rst & (count != CW'(FIFO_DEPTH));
    assign push = bus.arb_en & (|bus.grant);
    assign pop = bus.out_valid & bus.out_ready;
    assign bus.req_ack = push ? bus.grant : '0;
    assign bus.out_valid = count != '0;
    assign bus.out_data = data_mem[rd_ptr];
    assign bus.out_id = id_mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                id_mem[i] <= '0;
            end
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                data_mem[wr_ptr] <= sel_data;
                id_mem[wr_ptr] <= idx;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) onehot_err <= 1'b0;
        else if (push && (bus.grant & (bus.grant - 1'b1)) != '0) onehot_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_arb_grant_mux.sv
// tb_arb_grant_mux: directed plus randomized stimulus with a queue scoreboard and decoupled monitor
module tb_arb_grant_mux;
    localparam int REQ_NUM = 11;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
    logic onehot_err;
    logic exp_err = 1'b0;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int mcount = 0;
    int id_q[$];
    logic [DW-1:0] dat_q[$];
    arb_grant_mux_if #(.REQ_NUM(REQ_NUM), .DW(DW)) bus ();
    arb_grant_mux #(.REQ_NUM(REQ_NUM), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
        .onehot_err(onehot_err),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int lowest(input logic [REQ_NUM-1:0] g);
        for (int i = 0; i < REQ_NUM; i++) if (g[i]) return i;
        return 0;
    endfunction
    task automatic cyc(input logic [REQ_NUM-1:0] g, input logic rdy, input bit keep = 0);
        bit push, pop;
        int idx;
        bus.grant = g;
        bus.out_ready = rdy;
        if (!keep) for (int i = 0; i < REQ_NUM; i++) bus.req_data[i*DW +: DW] = $urandom;
        @(negedge clk);
        pop = (mcount != 0) && rdy;
        push = (mcount != DEPTH) && (g != '0);
        chk("arb_en", 64'(bus.arb_en), 64'(mcount != DEPTH));
        chk("req_ack", 64'(bus.req_ack), push ? 64'(g) : 64'd0);
        chk("out_valid", 64'(bus.out_valid), 64'(mcount != 0));
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
        chk("onehot_err", 64'(onehot_err), 64'(exp_err));
        if (push && $countones(g) > 1) exp_err = 1'b1;
`endif
        if (push) begin
            idx = lowest(g);
            id_q.push_back(idx);
            dat_q.push_back(bus.req_data[idx*DW +: DW]);
        end
        mcount += int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (id_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got id %0d with nothing expected", bus.out_id);
                end else begin
                    chk("out_id", 64'(bus.out_id), 64'(id_q.pop_front()));
                    chk("out_data", 64'(bus.out_data), 64'(dat_q.pop_front()));
                end
            end
        end
    end
    initial begin
        logic [REQ_NUM-1:0] g;
        int r;
        bus.grant = 11'h004;
        bus.out_ready = 1'b0;
        bus.req_data = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_arb_en", 64'(bus.arb_en), 0);
            chk("rst_req_ack", 64'(bus.req_ack), 0);
            chk("rst_out_valid", 64'(bus.out_valid), 0);
            chk("rst_out_data", 64'(bus.out_data), 0);
            chk("rst_out_id", 64'(bus.out_id), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        cyc(11'h004, 1'b1, 1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc(11'h020, 1'b0);
        cyc(11'h080, 1'b0);
        cyc(11'h200, 1'b0);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        cyc(11'h008, 1'b0);
        cyc(11'h100, 1'b1);
        cyc('0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(REQ_NUM'(1) << i, 1'b1);
        cyc('0, 1'b1);
        cyc(11'h002, 1'b0);
        cyc(11'h400, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
        chk("mid_rst_arb_en", 64'(bus.arb_en), 0);
        id_q.delete();
        dat_q.delete();
        mcount = 0;
`ifdef ARB_GRANT_MUX_ONEHOT_CHK_EN
        exp_err = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(11'h024, 1'b1);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            g = (r < 3) ? '0 : (r == 9) ? REQ_NUM'($urandom) : REQ_NUM'(1) << $urandom_range(0, REQ_NUM - 1);
            cyc(g, 1'($urandom_range(0, 1)));
        end
        repeat (4) cyc('0, 1'b1);
        chk("drained", 64'(id_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arb_grant_mux.md
Name: arb_grant_mux

Overview:
Downstream stage of the loop arbiter (loop_arb). Consumes its one-hot grant and selects the winning requester's payload. Pushes {id, payload} into a small output FIFO with a valid/ready interface. Drives arb_en back to the arbiter so that no grant is consumed, and the arbiter's priority does not rotate, while the FIFO is full.

Parameters:
- REQ_NUM, 11, number of requesters; must match loop_arb REQ_NUM.
- DW, 32, payload width per requester.
- FIFO_DEPTH, 2, output FIFO entries; power of 2, at least 2.
- IW, $clog2(REQ_NUM), id width (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- grant  in  REQ_NUM  one-hot grant from loop_arb; combinational in the current cycle.
- req_data  in  REQ_NUM*DW  payloads; requester i occupies bits [i*DW +: DW].
- arb_en  out  1  arbitration enable to loop_arb.
- req_ack  out  REQ_NUM  one-hot acknowledge; the granted requester drops or advances its request on this.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DW  payload at the FIFO head.
- out_id  out  IW  index of the requester whose payload is at the head.

Behaviour:
- Reset (rst=1, asynchronous): count=0, wr_ptr=0, rd_ptr=0, out_valid=0, arb_en=0, req_ack=0.
  - out_data and out_id are 0 from the reset-cleared storage.
  - Any entries held at the moment rst asserts are discarded.
- arb_en = ~rst & (count != FIFO_DEPTH).
  - Depends on registered count only; no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- push = arb_en & (|grant).
- req_ack = grant when push, otherwise 0. Combinational, same cycle as grant.
- On push:
  - Encode grant to an index: lowest set bit wins.
  - Write {idx, req_data[idx]} at wr_ptr.
  - Advance wr_ptr by 1 modulo FIFO_DEPTH; wraps naturally.
- pop = out_valid & out_ready. On pop, rd_ptr advances by 1 modulo FIFO_DEPTH.
- Count update: push only → +1; pop only → -1; push and pop together → unchanged.
  - Push and pop together is legal only when 0 < count < FIFO_DEPTH.
- out_valid = (count != 0). out_data and out_id are read from rd_ptr as direct register reads.
- Latency: a push at edge N gives out_valid at N+1 (first-word case). There is no bypass from grant to out_data.
- Ordering: strict FIFO in grant order.
- A pop at full frees one slot; arb_en rises in the following cycle.
- grant=0 while arb_en=1: no push, req_ack=0, state unchanged apart from any pop.
- Downstream protocol: out_data and out_id are stable while out_valid=1 and out_ready=0. out_valid never drops without a pop.
- State summary (encoded in count): EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY→PARTIAL: push.
  - PARTIAL→FULL: push without pop.
  - PARTIAL→EMPTY: pop without push at count=1.
  - FULL→PARTIAL: pop.

Optional Feature:
- Macro ARB_GRANT_MUX_ONEHOT_CHK_EN.
- Defined:
  - Adds output port onehot_err (1 bit). It is a sticky register, cleared only by rst.
  - onehot_err is set on the edge after any push where grant has more than one bit set.
  - The pushed entry still uses the lowest-set-bit index.
- Undefined: the port and checker are absent, and multi-hot grants are silently resolved lowest-bit-first.

Test Plan:
1. Reset check:
   - Hold rst=1 for 3 cycles with grant=11'h004 → arb_en=0, req_ack=0, out_valid=0.
   - The cycle rst falls → arb_en=1.
2. Single transfer:
   - grant=11'h004, req_data slot 2=32'hDEAD_BEEF, out_ready=1 → req_ack=11'h004 in the same cycle.
   - Next cycle: out_valid=1, out_data=32'hDEAD_BEEF, out_id=2.
   - Following cycle: out_valid=0.
3. Backpressure at full:
   - out_ready=0; grants bit 5, then bit 7, on consecutive cycles → count=2, arb_en=0 on the third cycle, req_ack=0 even with grant=11'h200.
   - Raise out_ready → pops id 5 then id 7; arb_en=1 the cycle after the first pop.
4. Simultaneous push/pop at count=1:
   - Head id 3, out_ready=1, grant bit 8 → count stays 1.
   - Next head id 8, data intact.
5. Streaming wrap:
   - out_ready=1; grants walk bits 0..9 over 10 consecutive cycles → out_id sequence 0..9, each one cycle after its grant.
   - No bubbles; pointers wrap 5 times.
6. Mid-operation reset and option:
   - count=2, assert rst for 1 cycle → out_valid=0 immediately, arb_en=0, then 1 after release.
   - With ARB_GRANT_MUX_ONEHOT_CHK_EN: grant=11'h024 → onehot_err=1 on the next edge, pushed out_id=2.
